// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and FSM state for the
// two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester and memory bus of the arbiter.
// slave = arbiter side, master = requesters + memory.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1,
    input  wdata0, wdata1, mem_rdata,
    output ack, rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, addr0, addr1,
    output wdata0, wdata1, mem_rdata,
    input  ack, rdata,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_arb_select.sv
// mem_arb_select: one-hot winner from two requests.
// ptr names the requester favoured on a tie.
module mem_arb_select (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // pick a single winner, tie broken by ptr
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = ptr ? 2'b10 : 2'b01;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: 3-cycle IDLE/ACCESS/DONE arbiter, 2 ports.
// MEM_ARB_ROUND_ROBIN_EN: round-robin, else fixed prio.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_arb_if.slave bus
);

  state_t            state;
  logic [1:0]        grant;
  logic [NUM_REQ-1:0] winner;
  logic [NUM_REQ-1:0] ack_q;
  logic              ptr;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  mem_arb_select u_sel (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (grant)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // favour the requester not granted last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (state == IDLE && |bus.req) begin
      ptr <= grant[0];
    end
  end
`else
  assign ptr = 1'b0;
`endif

  // access FSM with registered memory and ack outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      winner   <= '0;
      ack_q    <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ack_q    <= '0;
          mem_we_q <= 1'b0;
          if (|bus.req) begin
            winner   <= grant;
            mem_we_q <= |(grant & bus.we);
            addr_q   <= grant[1] ? bus.addr1
                                 : bus.addr0;
            wdata_q  <= grant[1] ? bus.wdata1
                                 : bus.wdata0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_we_q) begin
            rdata_q <= bus.mem_rdata;
          end
          mem_we_q <= 1'b0;
          ack_q    <= winner;
          state    <= DONE;
        end
        DONE: begin
          ack_q <= '0;
          state <= IDLE;
        end
        default: begin
          ack_q    <= '0;
          mem_we_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter
// with a 256x8 falling-edge-write memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_arb_if bus();

  mem_arbiter #(.NUM_REQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(negedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    logic [1:0] ack;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         we_cnt = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // ack/rdata checker against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.ack != 2'b00) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'(bus.ack), 0);
      end else begin
        e = sb.pop_front();
        chk("ack", 32'(bus.ack), 32'(e.ack));
        chk("rdata", 32'(bus.rdata), 32'(e.rdata));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_we) we_cnt++;
  end

  task automatic push(int idx, logic wr,
                      logic [7:0] d);
    exp_t e;
    if (!wr) last_rd = d;
    e.ack   = (idx == 1) ? 2'b10 : 2'b01;
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  task automatic drive(int idx, logic wr,
                       logic [7:0] a, logic [7:0] d);
    if (idx == 1) begin
      bus.addr1  = a;
      bus.wdata1 = d;
    end else begin
      bus.addr0  = a;
      bus.wdata0 = d;
    end
    bus.we[idx]  = wr;
    bus.req[idx] = 1'b1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == 2'b00 && n < 20);
    chk("ack_seen", 32'(bus.ack != 2'b00), 1);
  endtask

  task automatic single(int idx, logic wr,
                        logic [7:0] a, logic [7:0] d,
                        string tag);
    int n;
    int w0;
    @(negedge clk);
    w0 = we_cnt;
    drive(idx, wr, a, d);
    push(idx, wr, d);
    wait_ack(n);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_we"}, we_cnt - w0, 32'(wr));
    bus.req = 2'b00;
    bus.we  = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int idx;
    bus.req    = 2'b00;
    bus.we     = 2'b00;
    bus.addr0  = 8'h00;
    bus.addr1  = 8'h00;
    bus.wdata0 = 8'h00;
    bus.wdata1 = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    rst_n = 1'b1;

    single(0, 1'b1, 8'h10, 8'hA5, "wr0");
    chk("mem10", 32'(mem[8'h10]), 32'hA5);
    single(1, 1'b0, 8'h10, 8'hA5, "rd1");
    single(1, 1'b1, 8'h55, 8'h3E, "wr1");
    chk("mem55", 32'(mem[8'h55]), 32'h3E);
    single(0, 1'b0, 8'h55, 8'h3E, "rd0");
    single(1, 1'b0, 8'h55, 8'h3E, "rd1b");

    @(negedge clk);
    bus.we    = 2'b00;
    bus.addr0 = 8'h10;
    bus.addr1 = 8'h55;
    bus.req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      idx = k % 2;
`else
      idx = 0;
`endif
      push(idx, 1'b0, (idx == 1) ? 8'h3E : 8'hA5);
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      chk("cont_lat", n, (k == 0) ? 2 : 3);
    end
    bus.req = 2'b00;

    @(negedge clk);
    drive(0, 1'b0, 8'h10, 8'h00);
    push(0, 1'b0, 8'hA5);
    @(negedge clk);
    drive(1, 1'b0, 8'h55, 8'h00);
    push(1, 1'b0, 8'h3E);
    wait_ack(n);
    chk("late0_lat", n, 1);
    chk("late0_ack", 32'(bus.ack), 32'h1);
    bus.req[0] = 1'b0;
    wait_ack(n);
    chk("late1_lat", n, 3);
    bus.req = 2'b00;

    @(negedge clk);
    drive(0, 1'b1, 8'h20, 8'h3C);
    @(posedge clk);
    #2;
    chk("mid_we", 32'(bus.mem_we), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(bus.mem_we), 0);
    chk("arst_ack", 32'(bus.ack), 0);
    chk("arst_addr", 32'(bus.mem_addr), 0);
    chk("arst_wdata", 32'(bus.mem_wdata), 0);
    chk("arst_rdata", 32'(bus.rdata), 0);
    bus.req = 2'b00;
    bus.we  = 2'b00;
    last_rd = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_ack", 32'(bus.ack), 0);
    end
    chk("mem20", 32'(mem[8'h20]), 0);
    rst_n = 1'b1;
    single(0, 1'b0, 8'h20, 8'h00, "post_rst");

    repeat (10) begin
      @(negedge clk);
      chk("idle_we", 32'(bus.mem_we), 0);
      chk("idle_ack", 32'(bus.ack), 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL declare parameter: NUM_REQ, default 2, number of requesters (fixed at 2 in this revision).
REQ-002 SHALL declare ports: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL declare ports: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL declare ports: req  input  2  per-requester access request, bit 0 = CPU, bit 1 = DMA/loader.
REQ-005 SHALL declare ports: we  input  2  per-requester write flag, sampled with req.
REQ-006 SHALL declare ports: addr0, addr1  input  8 each  per-requester address.
REQ-007 SHALL declare ports: wdata0, wdata1  input  8 each  per-requester write data.
REQ-008 SHALL declare ports: ack  output  2  one-cycle completion pulse per requester.
REQ-009 SHALL declare ports: rdata  output  8  read data, valid while ack is high.
REQ-010 SHALL declare ports: mem_addr  output  8; mem_wdata  output  8; mem_we  output  1  to the 256x8 memory.
REQ-011 SHALL declare ports: mem_rdata  input  8  combinational read data from the memory.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-013 IDLE: if any req bit set, SHALL select one winner, register winner's addr/wdata/we onto mem_addr/mem_wdata/mem_we, go to ACCESS; else stay IDLE.
REQ-014 ACCESS: mem_we SHALL be high for exactly this one cycle on writes, so the memory's falling-edge write lands mid-cycle; on reads, mem_we low.
REQ-015 ACCESS -> DONE unconditionally; at this rising edge rdata SHALL capture mem_rdata (reads only; writes leave rdata unchanged).
REQ-016 DONE: ack[winner] SHALL be high for exactly one cycle, mem_we low, then go to IDLE.
REQ-017 Latency: req seen in IDLE at edge N -> ack high in cycle N+2; throughput one access per 3 cycles.
REQ-018 req/we/addr/wdata SHALL be held stable by requester until ack; req still high in DONE is treated as a new request in the following IDLE.
REQ-019 Arbitration decisions SHALL occur only in IDLE; a req rising during ACCESS/DONE waits.
REQ-020 mem_addr/mem_wdata SHALL hold their last value outside ACCESS; ack SHALL never have both bits set.
REQ-021 Deasserting req during ACCESS/DONE SHALL not abort the access; ack still pulses.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, ack=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, priority pointer to requester 0.
REQ-023 Reset during ACCESS SHALL drop mem_we asynchronously; the interrupted access is lost and no ack is issued.
REQ-024 First arbitration after rst_n deasserts SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-025 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester not granted last SHALL win; pointer updates on each grant.
REQ-026 Macro undefined: fixed priority, requester 0 (CPU) SHALL always win simultaneous requests; no pointer register.

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold ADDR_W=8, DATA_W=8, and the FSM state enum.
REQ-028 Winner selection SHALL be a sub-module mem_arb_select (req + pointer in, one-hot grant out); FSM and datapath stay in mem_arbiter.

Verification
REQ-029 Single write: req=01, we=01, addr0=8'h10, wdata0=8'hA5 -> mem_we high one cycle, mem[8'h10]=8'hA5, ack=01 at cycle N+2.
REQ-030 Read back: req=10, we=00, addr1=8'h10 -> ack=10 at N+2 with rdata=8'hA5.
REQ-031 Contention: req=11 held four grants -> round-robin grants 0,1,0,1; fixed-priority grants 0,0,0,0 with requester 1 starved.
REQ-032 Late request: req1 rises while requester 0 in ACCESS -> requester 1 granted only after ack=01, in next IDLE.
REQ-033 Reset mid-write: rst_n low during ACCESS writing 8'h3C to 8'h20 -> mem_we falls immediately, no ack, state IDLE, outputs zero.
REQ-034 Idle: req=00 for 10 cycles -> mem_we=0, ack=00 throughout, state IDLE.
